branch_resolve_unit: RTL and testbench

Parametrised branch resolution and prediction unit for the 5-stage datapath.
- Evaluates the branch condition in EX over DATA_W-bit operands, signed or unsigned, and compares the outcome against the direction predicted at fetch.
- Trains a table of 2-bit saturating counters indexed by PC.
- Drives a registered flush/redirect pulse of configurable length to IF/ID.
- Replaces the single-width, combinational-only branch equator.

---
 rtl/bru_pkg.sv | 33 +++
 rtl/bru_compare.sv | 30 +++
 rtl/branch_resolve_unit.sv | 134 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// bru_pkg: shared constants for the branch resolve unit.
// Condition-select encodings, 2-bit predictor counter states and the
// saturating counter update helper.
package bru_pkg;

  // Condition select encodings (cond_i)
  localparam logic [2:0] COND_BLTU = 3'b000;
  localparam logic [2:0] COND_BGTU = 3'b001;
  localparam logic [2:0] COND_BEQ  = 3'b010;
  localparam logic [2:0] COND_BNE  = 3'b011;
  localparam logic [2:0] COND_BLT  = 3'b100;
  localparam logic [2:0] COND_BGT  = 3'b101;
  localparam logic [2:0] COND_BGE  = 3'b110;
  localparam logic [2:0] COND_RSVD = 3'b111;

  // 2-bit saturating counter states; MSB is the predicted direction
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Every entry starts weakly not-taken
  localparam logic [1:0] CTR_RESET = CTR_WNT;

  // Move one step toward taken (up=1) or not-taken, clamping at the ends
  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic up);
    if (up) begin
      return (ctr == CTR_ST) ? CTR_ST : ctr + 2'b01;
    end
    return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/bru_compare.sv
// bru_compare: combinational branch condition evaluator over DATA_W-bit
// operands. Signed conditions use two's complement; 111 is never true.
module bru_compare
  import bru_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        cond,
  output logic              cond_true
);

  // Select the comparison named by cond
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_BLTU: cond_true = (a < b);
      COND_BGTU: cond_true = (a > b);
      COND_BEQ:  cond_true = (a == b);
      COND_BNE:  cond_true = (a != b);
      COND_BLT:  cond_true = ($signed(a) < $signed(b));
      COND_BGT:  cond_true = ($signed(a) > $signed(b));
      COND_BGE:  cond_true = ($signed(a) >= $signed(b));
      COND_RSVD: cond_true = 1'b0;
      default:   cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves EX-stage branches/jumps, detects
// mispredicts, drives a registered FLUSH_CYCLES-long flush with redirect
// direction, and (when BRU_PREDICTOR_EN is defined) trains a table of
// 2-bit saturating counters indexed by the low PC bits. Without
// BRU_PREDICTOR_EN the unit behaves as a static not-taken predictor.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int PC_W         = 16,
  parameter int BHT_DEPTH    = 16,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   fetch_pc_i,
  output logic              predict_taken_o,
  input  logic              valid_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [2:0]        cond_i,
  input  logic              branch_i,
  input  logic              jump_i,
  input  logic              predicted_taken_i,
  output logic              flush_o,
  output logic              redirect_taken_o,
  output logic              busy_o
);

  localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  logic             cond_true;
  logic             taken;
  logic             resolve;
  logic             mispredict;
  logic             train;
  logic             pred_eff;
  logic [CNT_W-1:0] flush_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_next;
  logic             redirect_reg;
  logic             redirect_next;

  bru_compare #(
    .DATA_W(DATA_W)
  ) u_compare (
    .a         (a_i),
    .b         (b_i),
    .cond      (cond_i),
    .cond_true (cond_true)
  );

  // Flush window is active whenever the counter is non-zero
  assign busy_o           = (flush_cnt_reg != '0);
  assign flush_o          = busy_o;
  assign redirect_taken_o = redirect_reg;

  // Resolve the EX instruction; anything arriving during a flush is wrong-path
  always_comb begin
    taken      = jump_i | (branch_i & cond_true);
    resolve    = valid_i & (branch_i | jump_i) & ~busy_o;
    mispredict = resolve & (taken != pred_eff);
    train      = resolve & branch_i & ~jump_i;
  end

  // Next flush count and redirect direction
  always_comb begin
    flush_cnt_next = flush_cnt_reg;
    redirect_next  = redirect_reg;
    if (mispredict) begin
      flush_cnt_next = CNT_W'(FLUSH_CYCLES);
      redirect_next  = taken;
    end else if (flush_cnt_reg != '0) begin
      flush_cnt_next = flush_cnt_reg - CNT_W'(1);
    end
  end

  // Flush counter and redirect register
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_cnt_reg <= '0;
      redirect_reg  <= 1'b0;
    end else begin
      flush_cnt_reg <= flush_cnt_next;
      redirect_reg  <= redirect_next;
    end
  end

`ifdef BRU_PREDICTOR_EN
  logic [1:0]       ctr_reg  [BHT_DEPTH];
  logic [1:0]       ctr_next [BHT_DEPTH];
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] train_idx;
  logic             unused_pc_bits;

  assign fetch_idx       = fetch_pc_i[IDX_W-1:0];
  assign train_idx       = pc_i[IDX_W-1:0];
  // Lookup reads the registered table, so a same-cycle update is not bypassed
  assign predict_taken_o = ctr_reg[fetch_idx][1];
  assign pred_eff        = predicted_taken_i;
  // Upper PC bits alias onto the same entries and are deliberately dropped
  assign unused_pc_bits  = ^{fetch_pc_i, pc_i};

  generate
    for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_ctr
      assign ctr_next[gi] = (train && (train_idx == IDX_W'(gi)))
                          ? ctr_update(ctr_reg[gi], taken)
                          : ctr_reg[gi];
    end
  endgenerate

  // Counter table: reset to weakly not-taken, otherwise take trained value
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        ctr_reg[i] <= CTR_RESET;
      end
    end else begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        ctr_reg[i] <= ctr_next[i];
      end
    end
  end
`else
  logic unused_static;

  // Static not-taken: no table, the carried prediction is ignored
  assign predict_taken_o = 1'b0;
  assign pred_eff        = 1'b0;
  assign unused_static   = ^{fetch_pc_i, pc_i, predicted_taken_i, train};
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit (DATA_W=16, BHT_DEPTH=16,
// FLUSH_CYCLES=3). Works with or without BRU_PREDICTOR_EN defined.
module tb_branch_resolve_unit;

  localparam int FC = 3;
`ifdef BRU_PREDICTOR_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] fetch_pc_i;
  logic        predict_taken_o;
  logic        valid_i;
  logic [15:0] pc_i;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic [2:0]  cond_i;
  logic        branch_i;
  logic        jump_i;
  logic        predicted_taken_i;
  logic        flush_o;
  logic        redirect_taken_o;
  logic        busy_o;

  branch_resolve_unit #(
    .DATA_W(16), .PC_W(16), .BHT_DEPTH(16), .FLUSH_CYCLES(FC)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .fetch_pc_i        (fetch_pc_i),
    .predict_taken_o   (predict_taken_o),
    .valid_i           (valid_i),
    .pc_i              (pc_i),
    .a_i               (a_i),
    .b_i               (b_i),
    .cond_i            (cond_i),
    .branch_i          (branch_i),
    .jump_i            (jump_i),
    .predicted_taken_i (predicted_taken_i),
    .flush_o           (flush_o),
    .redirect_taken_o  (redirect_taken_o),
    .busy_o            (busy_o)
  );

  always #5 clk = ~clk;

  int applied    = 0;
  int miscompares = 0;

  // Reference model state
  int m_flush;
  bit m_redir;
  int m_ctr [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit cond_true_m(input int a, input int b, input int cond);
    int sa = (a >= 32768) ? a - 65536 : a;
    int sb = (b >= 32768) ? b - 65536 : b;
    case (cond)
      0: return a < b;
      1: return a > b;
      2: return a == b;
      3: return a != b;
      4: return sa < sb;
      5: return sa > sb;
      6: return sa >= sb;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit predict_m(input int fpc);
    if (!PRED_EN) return 1'b0;
    return m_ctr[fpc % 16] >= 2;
  endfunction

  task automatic model_reset();
    m_flush = 0;
    m_redir = 1'b0;
    for (int i = 0; i < 16; i++) m_ctr[i] = 1;
  endtask

  // One clock: check outputs against the model, advance the model, clock the DUT
  task automatic tick();
    bit tk, pr, res;
    #1;
    check("flush", flush_o, m_flush > 0);
    check("busy", busy_o, m_flush > 0);
    check("redirect", redirect_taken_o, m_redir);
    check("predict", predict_taken_o, predict_m(fetch_pc_i));
    if (reset) begin
      model_reset();
    end else begin
      tk  = jump_i | (branch_i & cond_true_m(a_i, b_i, cond_i));
      pr  = PRED_EN ? predicted_taken_i : 1'b0;
      res = valid_i & (branch_i | jump_i) & (m_flush == 0);
      if (PRED_EN && res && branch_i && !jump_i) begin
        if (tk) m_ctr[pc_i % 16] = (m_ctr[pc_i % 16] == 3) ? 3 : m_ctr[pc_i % 16] + 1;
        else    m_ctr[pc_i % 16] = (m_ctr[pc_i % 16] == 0) ? 0 : m_ctr[pc_i % 16] - 1;
      end
      if (res && (tk != pr)) begin
        m_flush = FC;
        m_redir = tk;
      end else if (m_flush > 0) begin
        m_flush--;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    valid_i = 0; branch_i = 0; jump_i = 0; predicted_taken_i = 0;
  endtask

  task automatic drain();
    int guard = 0;
    while (m_flush > 0 && guard < 20) begin
      tick();
      guard++;
    end
    check("drain_bound", guard < 20, 1);
  endtask

  // One resolving instruction, then idle until any flush window closes
  task automatic apply(input logic [15:0] pc, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] cond, input logic br, input logic jp, input logic pred);
    valid_i = 1; pc_i = pc; a_i = a; b_i = b; cond_i = cond;
    branch_i = br; jump_i = jp; predicted_taken_i = pred;
    tick();
    idle_inputs();
    drain();
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 3))
      0: return 16'($urandom);
      1: return 16'($urandom_range(0, 2));
      2: return 16'h7FFF + 16'($urandom_range(0, 2));
      default: return 16'hFFFF;
    endcase
  endfunction

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  cond;
    logic        exp_flush;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int n;
    vecs[0]  = '{16'hFFFF, 16'h0001, 3'b000, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 3'b100, 1'b1};
    vecs[2]  = '{16'hFFFF, 16'h0001, 3'b001, 1'b1};
    vecs[3]  = '{16'hFFFF, 16'h0001, 3'b101, 1'b0};
    vecs[4]  = '{16'h1234, 16'h1234, 3'b010, 1'b1};
    vecs[5]  = '{16'h1234, 16'h1235, 3'b010, 1'b0};
    vecs[6]  = '{16'h1234, 16'h1235, 3'b011, 1'b1};
    vecs[7]  = '{16'h8000, 16'h7FFF, 3'b110, 1'b0};
    vecs[8]  = '{16'h7FFF, 16'h8000, 3'b110, 1'b1};
    vecs[9]  = '{16'h0005, 16'h0005, 3'b110, 1'b1};
    vecs[10] = '{16'h0005, 16'h0005, 3'b111, 1'b0};
    vecs[11] = '{16'h0000, 16'h0000, 3'b111, 1'b0};
    vecs[12] = '{16'h0003, 16'h0005, 3'b000, 1'b1};
    vecs[13] = '{16'h8000, 16'h8000, 3'b100, 1'b0};

    reset = 1; fetch_pc_i = 0; pc_i = 0; a_i = 0; b_i = 0; cond_i = 0;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    model_reset();
    tick();
    reset = 0;

    // Reset state
    #1;
    check("rst_flush", flush_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_redirect", redirect_taken_o, 0);
    check("rst_predict", predict_taken_o, 0);

    // Condition table: branch, predicted not-taken
    for (int i = 0; i < 14; i++) begin
      valid_i = 1; pc_i = 16'h0008; a_i = vecs[i].a; b_i = vecs[i].b;
      cond_i = vecs[i].cond; branch_i = 1; jump_i = 0; predicted_taken_i = 0;
      tick();
      idle_inputs();
      #1;
      check($sformatf("tbl%0d_flush", i), flush_o, vecs[i].exp_flush);
      if (vecs[i].exp_flush) check($sformatf("tbl%0d_redirect", i), redirect_taken_o, 1);
      drain();
    end

    // Flush length with a jump predicted not-taken
    valid_i = 1; jump_i = 1; branch_i = 0; predicted_taken_i = 0; pc_i = 16'h0010;
    tick();
    idle_inputs();
    n = 0;
    for (int k = 0; k < 6; k++) begin
      if (flush_o === 1'b1 && busy_o === 1'b1) n++;
      tick();
    end
    check("flush_len", n, FC);
    check("jump_redirect", redirect_taken_o, 1);

    // Wrong-path masking: mispredicting branches during the flush window
    fetch_pc_i = 16'h0007;
    valid_i = 1; jump_i = 1; branch_i = 0; predicted_taken_i = 0;
    tick();
    for (int k = 0; k < FC; k++) begin
      valid_i = 1; jump_i = 0; branch_i = 1; pc_i = 16'h0007;
      a_i = 16'h0042; b_i = 16'h0042; cond_i = 3'b010; predicted_taken_i = 0;
      tick();
    end
    idle_inputs();
    #1;
    check("wrongpath_noflush", flush_o, 0);
    check("wrongpath_notrain", predict_taken_o, 0);
    tick();

    // Saturation at pc 0x0005
    for (int k = 0; k < 4; k++) begin
      apply(16'h0005, 16'h0001, 16'h0001, 3'b010, 1, 0, 1);
      fetch_pc_i = 16'h0005;
      #1;
      check($sformatf("sat_up%0d", k), predict_taken_o, PRED_EN);
    end
    for (int k = 0; k < 4; k++) begin
      apply(16'h0005, 16'h0001, 16'h0001, 3'b011, 1, 0, 0);
    end
    fetch_pc_i = 16'h0005;
    #1;
    check("sat_down", predict_taken_o, 0);
    apply(16'h0005, 16'h0001, 16'h0001, 3'b010, 1, 0, 1);
    fetch_pc_i = 16'h0005;
    #1;
    check("sat_floor", predict_taken_o, 0);

    // Aliasing: 0x0003 and 0x0013 share an entry, 0x0004 does not
    fetch_pc_i = 16'h0013;
    #1;
    check("alias_before", predict_taken_o, 0);
    apply(16'h0003, 16'h0009, 16'h0002, 3'b001, 1, 0, 1);
    apply(16'h0003, 16'h0009, 16'h0002, 3'b001, 1, 0, 1);
    fetch_pc_i = 16'h0013;
    #1;
    check("alias_0013", predict_taken_o, PRED_EN);
    fetch_pc_i = 16'h0004;
    #1;
    check("alias_0004", predict_taken_o, 0);

    // Reset in the middle of a flush window
    valid_i = 1; jump_i = 1; branch_i = 0; predicted_taken_i = 0;
    tick();
    idle_inputs();
    tick();
    reset = 1;
    tick();
    reset = 0;
    #1;
    check("midrst_flush", flush_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_redirect", redirect_taken_o, 0);
    for (int i = 0; i < 16; i++) begin
      fetch_pc_i = 16'(i);
      #1;
      check($sformatf("midrst_entry%0d", i), predict_taken_o, 0);
    end
    tick();

    // Randomised traffic against the reference model
    for (int k = 0; k < 500; k++) begin
      reset             = ($urandom_range(0, 79) == 0);
      valid_i           = 1'($urandom_range(0, 3) != 0);
      branch_i          = 1'($urandom_range(0, 1));
      jump_i            = 1'($urandom_range(0, 4) == 0);
      predicted_taken_i = 1'($urandom_range(0, 1));
      pc_i              = 16'($urandom_range(0, 31));
      fetch_pc_i        = 16'($urandom_range(0, 31));
      a_i               = pick_operand();
      b_i               = pick_operand();
      cond_i            = 3'($urandom_range(0, 7));
      tick();
    end
    reset = 0;
    idle_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
